// File: rtl/psum_accumulator.sv
// Partial-sum accumulator: sums a packet of signed 32-bit terms through the
// carry-select adder and presents sum, term count and sticky overflow.

module carrySelectAdder32bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);
    localparam int BLK  = 4;
    localparam int NBLK = 32 / BLK;
    localparam logic [BLK:0] ONE = (BLK+1)'(1);

    logic [NBLK:0] carry;

    assign carry[0] = cin;

    genvar gi;
    generate
        for (gi = 0; gi < NBLK; gi++) begin : g_blk
            logic [BLK:0] s0;
            logic [BLK:0] s1;
            // Both carry-in cases are precomputed; the ripple carry only picks one.
            assign s0 = {1'b0, a[gi*BLK +: BLK]} + {1'b0, b[gi*BLK +: BLK]};
            assign s1 = s0 + ONE;
            assign sum[gi*BLK +: BLK] = carry[gi] ? s1[BLK-1:0] : s0[BLK-1:0];
            assign carry[gi+1]        = carry[gi] ? s1[BLK]     : s0[BLK];
        end
    endgenerate

    assign cout = carry[NBLK];
endmodule

module psum_accumulator #(
    parameter int DATA_W  = 32,
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic [COUNT_W-1:0] out_count,
    output logic               out_ovf
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t              state_reg, state_next;
    logic [DATA_W-1:0]   acc_reg, acc_next;
    logic [COUNT_W-1:0]  count_reg, count_next;
    logic                ovf_reg, ovf_next;

    logic [DATA_W-1:0]   adder_sum;
    logic                adder_cout_unused;
    logic                in_beat;
    logic                out_beat;
    logic                ovf_step;

    carrySelectAdder32bit u_adder (
        .a    (acc_reg),
        .b    (in_data),
        .cin  (1'b0),
        .sum  (adder_sum),
        .cout (adder_cout_unused)
    );

    assign in_beat  = in_valid & in_ready;
    assign out_beat = out_valid & out_ready;
    // Same-sign operands producing an opposite-sign result.
    assign ovf_step = (acc_reg[DATA_W-1] == in_data[DATA_W-1]) &&
                      (adder_sum[DATA_W-1] != acc_reg[DATA_W-1]);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            acc_reg   <= '0;
            count_reg <= '0;
            ovf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            count_reg <= count_next;
            ovf_reg   <= ovf_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (in_beat)  state_next = in_last ? ST_HOLD : ST_ACCUM;
            ST_ACCUM: if (in_beat && in_last) state_next = ST_HOLD;
            ST_HOLD:  if (out_beat) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        acc_next   = acc_reg;
        count_next = count_reg;
        ovf_next   = ovf_reg;
        if (in_beat) begin
            if (state_reg == ST_IDLE) begin
                acc_next   = in_data;
                count_next = COUNT_W'(1);
                ovf_next   = 1'b0;
            end else begin
                acc_next   = adder_sum;
                // Counter pins at all-ones; the sum keeps accumulating.
                count_next = (count_reg == '1) ? count_reg : count_reg + COUNT_W'(1);
                ovf_next   = ovf_reg | ovf_step;
            end
        end
    end

    always_comb begin
        in_ready  = (state_reg != ST_HOLD);
        out_valid = (state_reg == ST_HOLD);
    end

    assign out_data  = acc_reg;
    assign out_count = count_reg;
    assign out_ovf   = ovf_reg;
endmodule

// File: tb/tb_psum_accumulator.sv
// Directed bench for psum_accumulator: hand-computed packet sums, stalls,
// counter saturation, overflow flag and reset recovery.

module tb_psum_accumulator;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [7:0]  out_count;
    logic        out_ovf;

    int checks = 0;
    int errors = 0;

    psum_accumulator #(.DATA_W(32), .COUNT_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called and returns at a negedge; beat is taken on the posedge in between.
    task automatic put_beat(input logic [31:0] d, input logic l);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("beat_timeout", 32'd0, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic expect_result(input string tag, input logic [31:0] d,
                                 input logic [7:0] c, input logic o);
        int n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_data"},  out_data, d);
        check({tag, "_count"}, {24'd0, out_count}, {24'd0, c});
        check({tag, "_ovf"},   {31'd0, out_ovf}, {31'd0, o});
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_drained"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_ready"},   {31'd0, in_ready},  32'd1);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Back-to-back packet table with hand-computed results.
    localparam int NT = 9;
    localparam int NP = 4;
    logic [31:0] terms [NT] = '{32'd100, 32'hFFFF_FFCE, 32'd25,
                                32'h4000_0000, 32'h4000_0000,
                                32'd7,
                                32'h8000_0000, 32'h8000_0000, 32'd5};
    logic        lasts [NT] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [31:0] exp_sum [NP] = '{32'd75, 32'h8000_0000, 32'd7, 32'd5};
    logic [7:0]  exp_cnt [NP] = '{8'd3, 8'd2, 8'd1, 8'd3};
    logic        exp_ovf [NP] = '{1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        int p;
        int stall;
        reset = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_ready", {31'd0, in_ready},  32'd1);
        check("rst_data",  out_data, 32'd0);
        check("rst_count", {24'd0, out_count}, 32'd0);
        check("rst_ovf",   {31'd0, out_ovf},   32'd0);
        reset = 1'b0;
        @(negedge clk);

        // 5 + 7 - 2, result must be visible the cycle after the last beat
        put_beat(32'd5, 1'b0);
        put_beat(32'd7, 1'b0);
        put_beat(32'hFFFF_FFFE, 1'b1);
        $display("txn pkt3 data=%h count=%0d ovf=%0d", out_data, out_count, out_ovf);
        check("p3_latency", {31'd0, out_valid}, 32'd1);
        expect_result("p3", 32'd10, 8'd3, 1'b0);

        // Single beat held in HOLD while an extra beat is offered
        put_beat(32'h1234_5678, 1'b1);
        in_valid = 1'b1; in_data = 32'hDEAD_BEEF; in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", {31'd0, out_valid}, 32'd1);
            check("hold_data",  out_data, 32'h1234_5678);
            check("hold_ready", {31'd0, in_ready}, 32'd0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        $display("txn single data=%h count=%0d", out_data, out_count);
        expect_result("single", 32'h1234_5678, 8'd1, 1'b0);
        @(negedge clk);
        check("no_extra", {31'd0, out_valid}, 32'd0);

        // Signed overflow, then wrap-around with the flag cleared
        put_beat(32'h7FFF_FFFF, 1'b0);
        put_beat(32'd1, 1'b1);
        $display("txn ovf data=%h ovf=%0d", out_data, out_ovf);
        expect_result("ovf", 32'h8000_0000, 8'd2, 1'b1);
        put_beat(32'hFFFF_FFFF, 1'b0);
        put_beat(32'd1, 1'b1);
        $display("txn wrap data=%h ovf=%0d", out_data, out_ovf);
        expect_result("wrap", 32'd0, 8'd2, 1'b0);

        // Counter saturation
        for (int i = 0; i < 300; i++) put_beat(32'd1, (i == 299));
        $display("txn sat data=%0d count=%0d", out_data, out_count);
        expect_result("sat", 32'd300, 8'd255, 1'b0);

        // Reset mid-packet discards the partial sum
        put_beat(32'd9, 1'b0);
        put_beat(32'd9, 1'b0);
        pulse_reset();
        check("midrst_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_ready", {31'd0, in_ready},  32'd1);
        put_beat(32'd4, 1'b1);
        $display("txn after_rst data=%0d count=%0d", out_data, out_count);
        expect_result("after_rst", 32'd4, 8'd1, 1'b0);

        // Reset while holding a result drops it
        put_beat(32'd3, 1'b1);
        check("hrst_pre", {31'd0, out_valid}, 32'd1);
        pulse_reset();
        $display("txn hold_rst valid=%0d", out_valid);
        check("hrst_valid", {31'd0, out_valid}, 32'd0);
        check("hrst_ready", {31'd0, in_ready},  32'd1);

        // Back-to-back packets, in_valid high throughout, random output stalls
        p = 0;
        for (int i = 0; i < NT; i++) begin
            int n = 0;
            in_valid = 1'b1; in_data = terms[i]; in_last = lasts[i];
            while (!in_ready && n < 50) begin
                @(negedge clk);
                n++;
            end
            if (!in_ready) check("b2b_timeout", 32'd0, 32'd1);
            @(negedge clk);
            if (lasts[i]) begin
                if (i + 1 < NT) begin
                    in_data = terms[i+1]; in_last = lasts[i+1];
                end else begin
                    in_valid = 1'b0;
                end
                check("b2b_valid", {31'd0, out_valid}, 32'd1);
                check("b2b_data",  out_data, exp_sum[p]);
                check("b2b_count", {24'd0, out_count}, {24'd0, exp_cnt[p]});
                check("b2b_ovf",   {31'd0, out_ovf}, {31'd0, exp_ovf[p]});
                $display("txn b2b pkt=%0d data=%h count=%0d ovf=%0d", p, out_data, out_count, out_ovf);
                stall = $urandom_range(0, 3);
                for (int s = 0; s < stall; s++) begin
                    @(negedge clk);
                    check("b2b_stall_ready", {31'd0, in_ready}, 32'd0);
                    check("b2b_stall_data",  out_data, exp_sum[p]);
                end
                out_ready = 1'b1;
                @(negedge clk);
                out_ready = 1'b0;
                check("b2b_bubble_valid", {31'd0, out_valid}, 32'd0);
                check("b2b_bubble_ready", {31'd0, in_ready},  32'd1);
                p++;
            end
        end
        in_valid = 1'b0;
        check("b2b_packets", p, NP);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/psum_accumulator.md
Name: psum_accumulator

Overview:
- Sequential partial-sum accumulator placed directly downstream of the team's 32-bit carry-select adder (carrySelectAdder32bit), which it instantiates as its only add path.
- Accepts a stream of 32-bit two's-complement terms (MAC products or sparse-kernel partial sums) over a valid/ready handshake.
- Sums all terms of one output pixel, with the packet end marked by in_last.
- Presents the final sum, term count and a signed-overflow flag on a registered valid/ready output.

Parameters:
- DATA_W, 32, datapath width; fixed to 32, the adder width.
- COUNT_W, 8, width of the term counter out_count.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  in_data/in_last valid
- in_ready  output  1  block can accept a term this cycle
- in_data  input  32  signed term to accumulate
- in_last  input  1  final term of the current packet
- out_valid  output  1  result held on out_* outputs
- out_ready  input  1  consumer accepts result
- out_data  output  32  accumulated sum, modulo 2^32
- out_count  output  COUNT_W  number of terms in packet, saturating
- out_ovf  output  1  sticky signed overflow seen during packet

Behaviour:
- Reset values and effect:
  - Reset is sampled on the clk edge and overrides all other inputs.
  - After reset: state=IDLE, acc=0, out_data=0, out_count=0, out_ovf=0, out_valid=0, in_ready=1.
  - Reset mid-packet or while in HOLD discards the partial sum and any pending result with no output handshake.
- Handshakes:
  - Input beat accepted when in_valid & in_ready.
  - Output accepted when out_valid & out_ready.
- in_ready is combinational from state: 1 in IDLE and ACCUM, 0 in HOLD. It does not depend on in_valid.
- States:
  - IDLE: no packet in progress. On an accepted beat: acc <= in_data, count <= 1, ovf <= 0. If in_last=1, go to HOLD; otherwise go to ACCUM.
  - ACCUM: on an accepted beat, acc <= sum from carrySelectAdder32bit(acc, in_data) and count <= count+1. If in_last=1, go to HOLD. No beat: hold all state.
  - HOLD: out_valid=1, and out_data/out_count/out_ovf stay stable. On an output handshake, go to IDLE; out_valid=0 and in_ready=1 from the next cycle. No same-cycle bypass of a new input.
- Latency: last beat accepted at edge t produces out_valid=1 after edge t, i.e. the registered result is visible in cycle t+1.
- Throughput:
  - One term per cycle within a packet.
  - One bubble cycle minimum between the output handshake and the next packet's first beat.
- Arithmetic:
  - Sum is modulo 2^32; adder carry-out is discarded, so 0xFFFFFFFF + 1 = 0.
  - out_data is reported unsaturated.
  - ovf is set when acc[31] == in_data[31] and sum[31] != acc[31]. It is sticky until the next packet's first beat. The first beat never sets it.
- Counter: count saturates at 2^COUNT_W-1 and does not wrap. Accumulation continues past saturation.
- out_data and out_count mirror acc/count. They are only meaningful while out_valid=1.
- in_valid during HOLD is ignored. The producer must hold in_data/in_last until in_ready returns.
- out_ready while out_valid=0 is ignored.

Test Plan:
- Reset, then a 3-beat packet of 5, 7, -2 (last on beat 3) with out_ready=1 → out_valid one cycle after beat 3 with out_data=10, out_count=3, out_ovf=0, then out_valid=0 and in_ready=1 on the next cycle.
- Single beat 0x12345678 with in_last=1 → HOLD with out_data=0x12345678, out_count=1. Hold out_ready=0 for 5 cycles → out_valid, data and in_ready=0 stay stable; an offered in_valid beat is not consumed.
- Packet 0x7FFFFFFF, 1 (last) → out_data=0x80000000, out_ovf=1. The next packet -1, 1 → out_data=0, out_ovf=0 (carry-out ignored, flag cleared).
- 300 beats of value 1 with COUNT_W=8 → out_data=300, out_count=255.
- Assert reset mid-packet after 2 beats, then send packet 4 (last) → out_data=4, out_count=1, with no stale result emitted. Assert reset while in HOLD → out_valid=0 on the next cycle.
- Back-to-back packets with in_valid held high and random out_ready stalls → every sum matches the reference model, and exactly one bubble follows each output handshake.
